// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with optional write-to-read
// bypass and a per-register pending-write (claim) scoreboard.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   rd_addr_i           NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_used_i           per-port "operand consumed" qualifier for the stall
//   rd_data_o           NUM_RD packed read data (combinational)
//   busy_o              per-port unresolved pending write on the addressed register
//   stall_o             OR of busy_o & rd_used_i
//   wr_en_i/addr/data   writeback; also releases one claim on the register
//   claim_en_i/addr     reserve a register for an in-flight load
//   flush_i             drop all outstanding claims
//   err_o               sticky claim-overflow flag
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD-1:0]        rd_used_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        busy_o,
  output logic                     stall_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     claim_en_i,
  input  logic [ADDR_W-1:0]        claim_addr_i,
  input  logic                     flush_i,
  output logic                     err_o
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0]   r_mem     [NUM_REGS];
  logic [CNT_W-1:0]    r_cnt     [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_ovf;
  logic                w_wr_ok;
  logic                r_err;

  // Writes to register 0 are dropped when it is hardwired to zero
  assign w_wr_ok = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
      assign w_cnt_nxt[g] = '0;
      assign w_ovf[g]     = 1'b0;
    end else begin : g_cnt
      logic w_claim;
      logic w_rel;
      logic w_full;
      assign w_claim = claim_en_i && (claim_addr_i == ADDR_W'(g));
      assign w_rel   = wr_en_i && (wr_addr_i == ADDR_W'(g));
      assign w_full  = (r_cnt[g] == CNT_MAX);
      // Flush wins; claim and release together cancel; count saturates both ways
      assign w_cnt_nxt[g] = flush_i                           ? '0 :
                            (w_claim && !w_rel)               ? (w_full ? r_cnt[g] : r_cnt[g] + CNT_W'(1)) :
                            (w_rel && !w_claim && (r_cnt[g] != '0)) ? r_cnt[g] - CNT_W'(1) :
                                                                r_cnt[g];
      assign w_ovf[g] = !flush_i && w_claim && !w_rel && w_full;
    end

    // Per-register storage and claim counter
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_mem[g] <= '0;
        r_cnt[g] <= '0;
      end else begin
        if (w_wr_ok && (wr_addr_i == ADDR_W'(g))) r_mem[g] <= wr_data_i;
        r_cnt[g] <= w_cnt_nxt[g];
      end
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= r_err | (|w_ovf);
  end

  assign err_o = r_err;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic              w_byp;
    assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
    assign w_byp  = (BYPASS != 0) && wr_en_i && (wr_addr_i == w_addr);
    assign rd_data_o[k*DATA_W +: DATA_W] = w_zero ? '0 : (w_byp ? wr_data_i : r_mem[w_addr]);
    // The last pending write landing this cycle is bypassed, so it no longer blocks
    assign busy_o[k] = !w_zero && (r_cnt[w_addr] != '0) &&
                       !(w_byp && (r_cnt[w_addr] == CNT_W'(1)));
  end

  assign stall_o = |(busy_o & rd_used_i);

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb; one instance with bypass,
// one without, sharing all inputs. Expected values go into a queue when
// stimulus is applied and are popped when the outputs are sampled.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_used;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        flush;

  logic [63:0] a_rd,    b_rd;
  logic [1:0]  a_busy,  b_busy;
  logic        a_stall, b_stall;
  logic        a_err,   b_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_used_i(rd_used),
    .rd_data_o(a_rd), .busy_o(a_busy), .stall_o(a_stall),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_en_i(claim_en), .claim_addr_i(claim_addr), .flush_i(flush),
    .err_o(a_err)
  );

  regfile_sb #(.BYPASS(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_used_i(rd_used),
    .rd_data_o(b_rd), .busy_o(b_busy), .stall_o(b_stall),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_en_i(claim_en), .claim_addr_i(claim_addr), .flush_i(flush),
    .err_o(b_err)
  );

  task automatic ex(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; rd_used = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
    #1;
    ex("rst_rd", 64'h0);    chk({a_rd[31:0], b_rd[31:0]});
    ex("rst_busy", 64'h0);  chk(64'({a_busy, b_busy, a_stall, b_stall}));
    ex("rst_err", 64'h0);   chk(64'({a_err, b_err}));
    tick(); tick();
    rst = 1'b0;

    // All registers read zero after reset
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      ex("init_rd_a", 64'h0); chk(a_rd);
      ex("init_rd_b", 64'h0); chk(b_rd);
      tick();
    end
    ex("init_busy", 64'h0); chk(64'({a_busy, b_busy, a_err, b_err}));

    // Plain write, visible next cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_addr = {5'd0, 5'd5};
    #1;
    ex("wr5_a", 64'hDEADBEEF); chk(64'(a_rd[31:0]));
    ex("wr5_b", 64'hDEADBEEF); chk(64'(b_rd[31:0]));

    // Same-cycle bypass vs. registered-only read
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234; rd_addr = {5'd7, 5'd5};
    #1;
    ex("byp7_a", 64'h1234); chk(64'(a_rd[63:32]));
    ex("byp7_b", 64'h0);    chk(64'(b_rd[63:32]));
    tick();
    wr_en = 1'b0;
    #1;
    ex("post7_b", 64'h1234); chk(64'(b_rd[63:32]));

    // Claim r3: busy/stall from the next cycle, cleared by the write
    claim_en = 1'b1; claim_addr = 5'd3; rd_addr = {5'd7, 5'd3}; rd_used = 2'b01;
    #1;
    ex("claim3_same", 64'h0); chk(64'({a_busy, a_stall}));
    tick();
    claim_en = 1'b0;
    #1;
    ex("claim3_a", 64'h3); chk(64'({a_busy, a_stall}));
    ex("claim3_b", 64'h3); chk(64'({b_busy, b_stall}));
    rd_used = 2'b00;
    #1;
    ex("unused_stall", 64'h0); chk(64'({a_stall, b_stall}));
    rd_used = 2'b01;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    #1;
    ex("rel3_a", 64'h55); chk({29'h0, a_busy, a_stall, a_rd[31:0]});
    ex("rel3_b", 64'h3);  chk(64'({b_busy, b_stall}));
    tick();
    wr_en = 1'b0;
    #1;
    ex("rel3_next", 64'h55); chk({28'h0, a_busy, b_busy, b_rd[31:0]});

    // Register 0: writes and claims have no effect, no overflow
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    claim_en = 1'b1; claim_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    #1;
    ex("r0_same", 64'h0); chk(a_rd);
    tick();
    wr_en = 1'b0;
    tick(); tick(); tick();
    claim_en = 1'b0;
    #1;
    ex("r0_rd", 64'h0);   chk(a_rd | b_rd);
    ex("r0_flags", 64'h0); chk(64'({a_busy, b_busy, a_err, b_err}));

    // Flush overrides a same-cycle claim; the data write still happens
    claim_en = 1'b1; claim_addr = 5'd2;
    tick();
    claim_addr = 5'd9;
    tick();
    claim_en = 1'b0; rd_addr = {5'd9, 5'd2};
    #1;
    ex("claim29", 64'hF); chk(64'({a_busy, b_busy}));
    flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    #1;
    ex("flush_cyc_a", 64'h1); chk(64'(a_busy));
    tick();
    flush = 1'b0; claim_en = 1'b0; wr_en = 1'b0;
    #1;
    ex("flush_busy", 64'h0); chk(64'({a_busy, b_busy}));
    ex("flush_wr", 64'h99);  chk(64'(b_rd[63:32]));

    // Overflow on r4: fourth claim dropped, err sticky
    claim_en = 1'b1; claim_addr = 5'd4; rd_addr = {5'd4, 5'd4};
    tick(); tick(); tick();
    ex("ovf_pre_err", 64'h0); chk(64'({a_err, b_err}));
    tick();
    claim_en = 1'b0;
    #1;
    ex("ovf_err", 64'h3);  chk(64'({a_err, b_err}));
    ex("ovf_busy", 64'hF); chk(64'({a_busy, b_busy}));
    // Claim and release together at max: count unchanged
    claim_en = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    tick();
    claim_en = 1'b0;
    tick(); tick();
    // Two releases taken; one claim left, being released now
    ex("rel4_2_a", 64'h0); chk(64'(a_busy));
    ex("rel4_2_b", 64'h3); chk(64'(b_busy));
    tick();
    wr_en = 1'b0;
    #1;
    ex("rel4_done", 64'h0); chk(64'({a_busy, b_busy}));
    ex("err_sticky", 64'h3); chk(64'({a_err, b_err}));

    // Asynchronous reset mid-operation
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hAA;
    tick();
    wr_en = 1'b0; claim_en = 1'b1; claim_addr = 5'd6;
    tick(); tick();
    claim_en = 1'b0; rd_addr = {5'd6, 5'd6};
    #1;
    ex("pre_rst_rd", 64'h0000_00AA_0000_00AA); chk(a_rd);
    ex("pre_rst_busy", 64'hF);                 chk(64'({a_busy, b_busy}));
    #2;
    rst = 1'b1;
    #1;
    ex("async_rd", 64'h0);    chk(a_rd | b_rd);
    ex("async_flags", 64'h0); chk(64'({a_busy, b_busy, a_stall, b_stall, a_err, b_err}));
    tick();
    rst = 1'b0;
    tick();
    ex("post_rst", 64'h0); chk(64'({a_busy, b_busy, a_err, b_err}) | 64'(a_rd[31:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
